// File: rtl/multi_deque.sv
// ---------------------------------------------------------------------------
// multi_deque
//   CHANNELS independent double-ended queues, each DEPTH words of WIDTH bits,
//   sharing one storage array and one read port. Each cycle at most one
//   channel (the one on sel) is pushed, popped, peeked or cleared.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   sel         channel addressed by push/pop/peek/clear
//   end_select  0 = front end, 1 = back end (shared by push and pop/peek)
//   push        write data_in at the selected end
//   pop         read and remove the word at the selected end
//   peek        read the word at the selected end without removing it
//   clear       flush channel sel and drop its sticky flags
//   data_in     push data
//   data_out    registered read data, held between reads
//   valid_out   one-cycle pulse when data_out was loaded by a read
//   empty/full  per-channel occupancy flags
//   count       word count of channel sel (combinational on sel)
//   overflow    per-channel sticky flag, rejected push
//   underflow   per-channel sticky flag, rejected pop/peek
// ---------------------------------------------------------------------------
module multi_deque #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel,
    input  logic                end_select,
    input  logic                push,
    input  logic                pop,
    input  logic                peek,
    input  logic                clear,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    data_out,
    output logic                valid_out,
    output logic [CHANNELS-1:0] empty,
    output logic [CHANNELS-1:0] full,
    output logic [CNT_W-1:0]    count,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem  [CHANNELS][DEPTH];
    logic [PTR_W-1:0] head [CHANNELS];
    logic [PTR_W-1:0] tail [CHANNELS];
    logic [CNT_W-1:0] cnt  [CHANNELS];

    logic             sel_ok;
    logic [PTR_W-1:0] cur_head, cur_tail;
    logic [CNT_W-1:0] cur_cnt;
    logic             is_empty, is_full;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_word;
    logic             act;
    logic             pop_ok, peek_ok, rd_rej;
    logic             push_ok, push_rej;
    logic             pop_front, pop_back, push_front, push_back;
    logic [PTR_W-1:0] head_nx, tail_nx, wr_addr;
    logic [CNT_W-1:0] cnt_nx;

    // Guards against sel codes beyond CHANNELS when CHANNELS is not a power of two.
    assign sel_ok = (int'(sel) < CHANNELS);

    always_comb begin
        cur_head   = head[sel];
        cur_tail   = tail[sel];
        cur_cnt    = cnt[sel];
        is_empty   = (cur_cnt == '0);
        is_full    = (cur_cnt == CNT_W'(DEPTH));

        // Back end lives one slot below tail.
        rd_ptr     = end_select ? (cur_tail - PTR_W'(1)) : cur_head;
        rd_word    = mem[sel][rd_ptr];

        act        = sel_ok && !clear;
        pop_ok     = act && pop && !is_empty;
        peek_ok    = act && peek && !pop && !is_empty;
        rd_rej     = act && (pop || peek) && is_empty;
        // A successful pop frees a slot in the same cycle, so a full channel
        // still accepts the push.
        push_ok    = act && push && (!is_full || pop_ok);
        push_rej   = act && push && is_full && !pop_ok;

        pop_front  = pop_ok  && !end_select;
        pop_back   = pop_ok  &&  end_select;
        push_front = push_ok && !end_select;
        push_back  = push_ok &&  end_select;

        // Front and back pointers move independently; a push and pop on the
        // same end cancel and the new word overwrites the slot just read.
        head_nx = cur_head;
        if (push_front && !pop_front)
            head_nx = cur_head - PTR_W'(1);
        else if (pop_front && !push_front)
            head_nx = cur_head + PTR_W'(1);

        tail_nx = cur_tail;
        if (push_back && !pop_back)
            tail_nx = cur_tail + PTR_W'(1);
        else if (pop_back && !push_back)
            tail_nx = cur_tail - PTR_W'(1);

        if (push_front)
            wr_addr = pop_front ? cur_head : (cur_head - PTR_W'(1));
        else
            wr_addr = pop_back ? (cur_tail - PTR_W'(1)) : cur_tail;

        cnt_nx = cur_cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);

        if (clear) begin
            head_nx = '0;
            tail_nx = '0;
            cnt_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
            overflow  <= '0;
            underflow <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok || peek_ok;
            if (pop_ok || peek_ok)
                data_out <= rd_word;
            if (sel_ok) begin
                head[sel] <= head_nx;
                tail[sel] <= tail_nx;
                cnt[sel]  <= cnt_nx;
                if (clear) begin
                    overflow[sel]  <= 1'b0;
                    underflow[sel] <= 1'b0;
                end else begin
                    if (push_rej)
                        overflow[sel] <= 1'b1;
                    if (rd_rej)
                        underflow[sel] <= 1'b1;
                end
            end
        end
    end

    // Storage is not reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[sel][wr_addr] <= data_in;
    end

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i] = (cnt[i] == '0);
            full[i]  = (cnt[i] == CNT_W'(DEPTH));
        end
    end

    assign count = sel_ok ? cur_cnt : '0;

endmodule

// File: tb/tb_multi_deque.sv
module tb_multi_deque;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          sel;
    logic                end_select;
    logic                push, pop, peek, clear;
    logic [WIDTH-1:0]    data_in;
    logic [WIDTH-1:0]    data_out;
    logic                valid_out;
    logic [CHANNELS-1:0] empty, full, overflow, underflow;
    logic [4:0]          count;

    always #5 clk = ~clk;

    multi_deque #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sel(sel), .end_select(end_select),
        .push(push), .pop(pop), .peek(peek), .clear(clear),
        .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
        .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // Reference model: one queue per channel, front = index 0.
    logic [WIDTH-1:0]    mq [CHANNELS][$];
    logic [WIDTH-1:0]    sb [$];
    logic [CHANNELS-1:0] m_ovf, m_unf;
    logic [WIDTH-1:0]    m_data;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHANNELS-1:0] m_empty();
        logic [CHANNELS-1:0] v;
        for (int i = 0; i < CHANNELS; i++) v[i] = (mq[i].size() == 0);
        return v;
    endfunction

    function automatic logic [CHANNELS-1:0] m_full();
        logic [CHANNELS-1:0] v;
        for (int i = 0; i < CHANNELS; i++) v[i] = (mq[i].size() == DEPTH);
        return v;
    endfunction

    task automatic check_flags(input string tag, input int s);
        chk({tag, ":count"},     count,     32'(mq[s].size()));
        chk({tag, ":empty"},     empty,     m_empty());
        chk({tag, ":full"},      full,      m_full());
        chk({tag, ":overflow"},  overflow,  m_ovf);
        chk({tag, ":underflow"}, underflow, m_unf);
    endtask

    task automatic op(input string tag, input int s, input logic e,
                      input logic pu, input logic po, input logic pk,
                      input logic cl, input logic [WIDTH-1:0] d);
        logic exp_v;
        logic popped;
        int   n;
        exp_v  = 1'b0;
        popped = 1'b0;
        sel = 2'(s); end_select = e; push = pu; pop = po; peek = pk;
        clear = cl; data_in = d;
        n = mq[s].size();
        if (cl) begin
            mq[s].delete();
            m_ovf[s] = 1'b0;
            m_unf[s] = 1'b0;
        end else begin
            if (po || pk) begin
                if (n == 0) m_unf[s] = 1'b1;
                else begin
                    exp_v = 1'b1;
                    sb.push_back(e ? mq[s][n-1] : mq[s][0]);
                    if (po) begin
                        popped = 1'b1;
                        if (e) void'(mq[s].pop_back());
                        else   void'(mq[s].pop_front());
                    end
                end
            end
            if (pu) begin
                if (n == DEPTH && !popped) m_ovf[s] = 1'b1;
                else if (e) mq[s].push_back(d);
                else        mq[s].push_front(d);
            end
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; peek = 1'b0; clear = 1'b0;
        chk({tag, ":valid_out"}, valid_out, exp_v);
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) chk({tag, ":sb_has_entry"}, 0, 1);
            else m_data = sb.pop_front();
        end
        chk({tag, ":data_out"}, data_out, m_data);
        check_flags(tag, s);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sel = 2'd2; end_select = 1'b1; push = 1'b1; pop = 1'b1; data_in = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        for (int i = 0; i < CHANNELS; i++) mq[i].delete();
        sb.delete();
        m_ovf = '0; m_unf = '0; m_data = '0;
        chk({tag, ":valid_out"}, valid_out, 0);
        chk({tag, ":data_out"},  data_out,  0);
        check_flags(tag, 2);
    endtask

    task automatic check_counts(input string tag);
        for (int c = 0; c < CHANNELS; c++) begin
            sel = 2'(c);
            #1;
            chk($sformatf("%s:count_ch%0d", tag, c), count, 32'(mq[c].size()));
        end
    endtask

    initial begin
        rst = 1'b1; sel = '0; end_select = 1'b0; push = 1'b0; pop = 1'b0;
        peek = 1'b0; clear = 1'b0; data_in = '0;
        m_ovf = '0; m_unf = '0; m_data = '0;
        @(posedge clk);
        do_reset("reset0");
        check_counts("reset0");

        // FIFO use: push back, pop front
        op("p37_push", 0, 1, 1, 0, 0, 0, 8'h11);
        op("p37_push", 0, 1, 1, 0, 0, 0, 8'h22);
        op("p37_push", 0, 1, 1, 0, 0, 0, 8'h33);
        for (int i = 0; i < 3; i++) op("p37_pop", 0, 0, 0, 1, 0, 0, 8'h00);

        // Fill ch2 from the front, overflow, pop back
        for (int i = 0; i < DEPTH; i++) op("p38_fill", 2, 0, 1, 0, 0, 0, 8'(8'hA0 + i));
        op("p38_ovf", 2, 0, 1, 0, 0, 0, 8'hB0);
        op("p38_popb", 2, 1, 0, 1, 0, 0, 8'h00);
        op("p38_peekf", 2, 0, 0, 0, 1, 0, 8'h00);

        // Underflow on empty ch1, then clear
        op("p39_pop_empty", 1, 0, 0, 1, 0, 0, 8'h00);
        op("p39_peek_empty", 1, 1, 0, 0, 1, 0, 8'h00);
        op("p39_clear", 1, 0, 0, 0, 0, 1, 8'h00);
        // Empty channel: pop rejected but concurrent push lands
        op("pop_push_empty", 1, 1, 1, 1, 0, 0, 8'h5A);
        op("pop_after", 1, 0, 0, 1, 0, 0, 8'h00);
        // clear wins over a concurrent push
        op("clear_push", 1, 0, 1, 0, 0, 1, 8'h99);

        // Single-word ch3: push+pop on one end returns old word, count stays 1
        op("p40_seed", 3, 1, 1, 0, 0, 0, 8'h05);
        op("p40_pushpop", 3, 0, 1, 1, 0, 0, 8'h06);
        op("p40_peek", 3, 0, 0, 0, 1, 0, 8'h00);
        op("peek_push", 3, 1, 1, 0, 1, 0, 8'h07);
        op("pop_wins", 3, 0, 0, 1, 1, 0, 8'h00);

        // Full ch0: push+pop back keeps it full with no overflow
        for (int i = 0; i < DEPTH; i++) op("p41_fill", 0, 1, 1, 0, 0, 0, 8'(8'h40 + i));
        op("p41_pushpop", 0, 1, 1, 1, 0, 0, 8'h77);
        op("p41_peekb", 0, 1, 0, 0, 1, 0, 8'h00);
        op("full_pushpop_f", 0, 0, 1, 1, 0, 0, 8'h78);
        check_counts("p41");
        op("clear_ovf", 2, 0, 0, 0, 0, 1, 8'h00);

        // Reset mid-sequence
        for (int i = 0; i < 5; i++) op("p42_push", 2, 1, 1, 0, 0, 0, 8'(8'hC0 + i));
        do_reset("p42_reset");
        check_counts("p42");
        op("p42_pop_after", 2, 0, 0, 1, 0, 0, 8'h00);
        op("p42_pop_ch0", 0, 1, 0, 1, 0, 0, 8'h00);

        // Random mix against the model
        for (int k = 0; k < 400; k++) begin
            op("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 30),
               1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 3),
               8'($urandom));
        end
        check_counts("rand");
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
